// File: rtl/slave_port_sched_pkg.sv
// Shared types and helpers for the per-slave transaction scheduler.
// Optional read-response timeout is enabled with SLAVE_PORT_SCHED_TIMEOUT_EN.
package slave_port_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam int DEFAULT_NUM_MASTERS = 4;

    // Binary index of a one-hot vector; 0 for an all-zero vector.
    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/slave_port_sched_rr_pick.sv
// Rotating-priority picker: first set req scanning upward from ptr+1 with wrap.
// Purely combinational, zero latency; no backpressure of its own.
module slave_port_sched_rr_pick #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic [NUM_MASTERS-1:0] win,
    output logic                   vld
);

    always_comb begin
        win = '0;
        vld = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            if (!vld && req[(int'(ptr) + k) % NUM_MASTERS]) begin
                win[(int'(ptr) + k) % NUM_MASTERS] = 1'b1;
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/slave_port_sched.sv
// Per-slave round-robin scheduler: 1 cycle req->gnt, grant held until slave_ack.
// One transaction in flight; reads block new grants until slave_resp
// (or, with SLAVE_PORT_SCHED_TIMEOUT_EN, until the response timeout expires).
module slave_port_sched
    import slave_port_sched_pkg::*;
#(
    parameter int NUM_MASTERS    = DEFAULT_NUM_MASTERS,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int IDX_W         = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [NUM_MASTERS-1:0] cmd,
    input  logic                   slave_ack,
    input  logic                   slave_resp,
    output logic                   slave_req,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [IDX_W-1:0]       gnt_idx,
    output logic [NUM_MASTERS-1:0] ack_out,
    output logic [NUM_MASTERS-1:0] resp_owner,
    output logic [NUM_MASTERS-1:0] resp_out,
    output logic                   stray_resp,
    output logic                   timeout
);

    state_t                 state, state_nxt;
    logic [NUM_MASTERS-1:0] gnt_nxt, resp_owner_nxt;
    logic [IDX_W-1:0]       ptr, ptr_nxt;
    logic                   stray_nxt;

    logic [NUM_MASTERS-1:0] idle_win, rep_win;
    logic                   idle_vld, rep_vld;
    logic                   win_is_write;

    assign gnt_idx      = IDX_W'(onehot_to_idx(32'(gnt)));
    assign slave_req    = |gnt;
    assign ack_out      = gnt & {NUM_MASTERS{slave_ack}};
    assign resp_out     = resp_owner & {NUM_MASTERS{slave_resp}};
    assign win_is_write = |(gnt & cmd);

    slave_port_sched_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_idle_pick (
        .req (req),
        .ptr (ptr),
        .win (idle_win),
        .vld (idle_vld)
    );

    // Back-to-back write re-pick: pointer already advanced to the current
    // winner, and the winner's own req is masked so it cannot win twice.
    slave_port_sched_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_rep_pick (
        .req (req & ~gnt),
        .ptr (gnt_idx),
        .win (rep_win),
        .vld (rep_vld)
    );

`ifdef SLAVE_PORT_SCHED_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             timeout_nxt;
`endif

    always_comb begin
        state_nxt      = state;
        gnt_nxt        = gnt;
        resp_owner_nxt = resp_owner;
        ptr_nxt        = ptr;
        stray_nxt      = slave_resp && (state != WAIT_RESP);
`ifdef SLAVE_PORT_SCHED_TIMEOUT_EN
        cnt_nxt        = cnt;
        timeout_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (idle_vld) begin
                    gnt_nxt   = idle_win;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (slave_ack) begin
                    ptr_nxt = gnt_idx;
                    if (win_is_write == CMD_WRITE) begin
                        if (rep_vld) begin
                            gnt_nxt = rep_win;
                        end else begin
                            gnt_nxt   = '0;
                            state_nxt = IDLE;
                        end
                    end else begin
                        resp_owner_nxt = gnt;
                        gnt_nxt        = '0;
                        state_nxt      = WAIT_RESP;
`ifdef SLAVE_PORT_SCHED_TIMEOUT_EN
                        cnt_nxt        = '0;
`endif
                    end
                end else if (!(|(req & gnt))) begin
                    gnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            WAIT_RESP: begin
                if (slave_resp) begin
                    resp_owner_nxt = '0;
                    state_nxt      = IDLE;
                end
`ifdef SLAVE_PORT_SCHED_TIMEOUT_EN
                else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    resp_owner_nxt = '0;
                    timeout_nxt    = 1'b1;
                    state_nxt      = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
`endif
            end
            default: begin
                gnt_nxt        = '0;
                resp_owner_nxt = '0;
                state_nxt      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= '0;
            resp_owner <= '0;
            ptr        <= IDX_W'(NUM_MASTERS - 1);
            stray_resp <= 1'b0;
        end else begin
            state      <= state_nxt;
            gnt        <= gnt_nxt;
            resp_owner <= resp_owner_nxt;
            ptr        <= ptr_nxt;
            stray_resp <= stray_nxt;
        end
    end

`ifdef SLAVE_PORT_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            timeout <= timeout_nxt;
        end
    end
`else
    // Without the timeout feature the limit has no effect.
    assign timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_slave_port_sched.sv
// Directed self-checking bench for slave_port_sched (4 masters, timeout limit 8).
module tb_slave_port_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req, cmd;
    logic       slave_ack, slave_resp;
    logic       slave_req;
    logic [3:0] gnt, ack_out, resp_owner, resp_out;
    logic [1:0] gnt_idx;
    logic       stray_resp, timeout;

    int checks = 0;
    int errors = 0;

    slave_port_sched #(
        .NUM_MASTERS    (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .cmd        (cmd),
        .slave_ack  (slave_ack),
        .slave_resp (slave_resp),
        .slave_req  (slave_req),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .ack_out    (ack_out),
        .resp_owner (resp_owner),
        .resp_out   (resp_out),
        .stray_resp (stray_resp),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0; cmd = '0; slave_ack = 1'b0; slave_resp = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_gnt_idx", gnt_idx, 2'd0);
        chk("rst_slave_req", slave_req, 1'b0);
        chk("rst_resp_owner", resp_owner, 4'b0000);
        chk("rst_stray", stray_resp, 1'b0);
        chk("rst_timeout", timeout, 1'b0);

        // Single write from master 0
        req = 4'b0001; cmd = 4'b0001;
        tick();
        chk("w0_gnt", gnt, 4'b0001);
        slave_ack = 1'b1;
        #1;
        chk("w0_ack_out", ack_out, 4'b0001);
        chk("w0_slave_req", slave_req, 1'b1);
        tick();
        req = 4'b0000; slave_ack = 1'b0;
        chk("w0_gnt_clear", gnt, 4'b0000);
        chk("w0_stray", stray_resp, 1'b0);

        // Pointer now 0: master 1 drops req before ack, then 0011 re-grants 1
        req = 4'b0010; cmd = 4'b0011;
        tick();
        chk("drop_gnt", gnt, 4'b0010);
        req = 4'b0000;
        tick();
        chk("drop_idle", gnt, 4'b0000);
        req = 4'b0011;
        tick();
        chk("drop_regnt", gnt, 4'b0010);
        chk("drop_regnt_idx", gnt_idx, 2'd1);
        req = 4'b0000;
        tick();

        // Back-to-back writes, all masters
        do_reset();
        req = 4'b1111; cmd = 4'b1111;
        tick();
        chk("b2b_0", gnt, 4'b0001);
        slave_ack = 1'b1;
        tick();
        chk("b2b_1", gnt, 4'b0010);
        tick();
        chk("b2b_2", gnt, 4'b0100);
        chk("b2b_2_idx", gnt_idx, 2'd2);
        tick();
        chk("b2b_3", gnt, 4'b1000);
        #1;
        chk("b2b_3_ack", ack_out, 4'b1000);
        tick();
        chk("b2b_4", gnt, 4'b0001);

        // Read by master 2 blocks master 0 until the response
        do_reset();
        req = 4'b0100; cmd = 4'b0000;
        tick();
        chk("rd_gnt", gnt, 4'b0100);
        slave_ack = 1'b1;
        tick();
        slave_ack = 1'b0; req = 4'b0001;
        chk("rd_owner", resp_owner, 4'b0100);
        chk("rd_gnt_clear", gnt, 4'b0000);
        for (int i = 0; i < 4; i++) tick();
        chk("rd_blocked", gnt, 4'b0000);
        chk("rd_no_stray", stray_resp, 1'b0);
        slave_resp = 1'b1;
        #1;
        chk("rd_resp_out", resp_out, 4'b0100);
        tick();
        slave_resp = 1'b0;
        chk("rd_owner_clear", resp_owner, 4'b0000);
        chk("rd_gnt_still0", gnt, 4'b0000);
        chk("rd_stray0", stray_resp, 1'b0);
        tick();
        chk("rd_next_gnt", gnt, 4'b0001);
        req = 4'b0000;
        tick();

        // Stray response in IDLE
        slave_resp = 1'b1;
        #1;
        chk("stray_resp_out", resp_out, 4'b0000);
        tick();
        slave_resp = 1'b0;
        chk("stray_pulse", stray_resp, 1'b1);
        chk("stray_gnt", gnt, 4'b0000);
        chk("stray_owner", resp_owner, 4'b0000);
        tick();
        chk("stray_end", stray_resp, 1'b0);

        // Read with no response
        do_reset();
        req = 4'b0100; cmd = 4'b0000;
        tick();
        slave_ack = 1'b1;
        tick();
        slave_ack = 1'b0; req = 4'b0000;
        chk("to_owner", resp_owner, 4'b0100);
`ifdef SLAVE_PORT_SCHED_TIMEOUT_EN
        for (int i = 0; i < 7; i++) tick();
        chk("to_owner_w8", resp_owner, 4'b0100);
        chk("to_not_yet", timeout, 1'b0);
        tick();
        chk("to_pulse", timeout, 1'b1);
        chk("to_owner_clear", resp_owner, 4'b0000);
        tick();
        chk("to_pulse_end", timeout, 1'b0);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("hold_owner", resp_owner, 4'b0100);
            chk("hold_no_timeout", timeout, 1'b0);
        end
        // Reset abandons the outstanding read
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_wait_owner", resp_owner, 4'b0000);
        slave_resp = 1'b1;
        #1;
        chk("rst_wait_resp_out", resp_out, 4'b0000);
        tick();
        slave_resp = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
